// File: rtl/pixel_frame_writer_pkg.sv
// Shared definitions for the pixel frame writer: state encoding, default
// geometry and the width of the running pixel sum.
package pixel_frame_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } pfw_state_t;

  localparam int DEF_IMG_W  = 256;
  localparam int DEF_IMG_H  = 256;
  localparam int DEF_ADDR_W = 16;
  // 256*256*255 fits in 24 bits, so the sum never wraps.
  localparam int SUM_W      = 24;

endpackage

// File: rtl/pixel_hold_reg.sv
// One-entry hold register between the pixel stream and the frame buffer.
// A load in the same cycle as a drain keeps the entry full (pass-through
// at one byte per clock).
module pixel_hold_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] din,
  input  logic       drain,
  output logic [7:0] dout,
  output logic       full
);

  logic [7:0] data_reg;
  logic       full_reg;

  // Capture a new byte on load; otherwise empty the slot when it drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg <= 8'd0;
      full_reg <= 1'b0;
    end else if (load) begin
      data_reg <= din;
      full_reg <= 1'b1;
    end else if (drain) begin
      full_reg <= 1'b0;
    end
  end

  assign dout = data_reg;
  assign full = full_reg;

endmodule

// File: rtl/pixel_frame_writer.sv
// Streams one frame of processed pixels into a frame buffer, row-major
// from address 0, with a one-entry hold stage so the buffer can stall
// writes without losing input bytes. Tracks rows, frame end and pixel sum.
module pixel_frame_writer
  import pixel_frame_writer_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_grant,
  output logic              busy,
  output logic              line_done,
  output logic              frame_done,
  output logic [SUM_W-1:0]  frame_sum
);

  localparam int                COL_W     = $clog2(IMG_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(IMG_W - 1);

  pfw_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [ADDR_W-1:0] acc_cnt_reg;   // bytes accepted so far this frame
  logic [COL_W-1:0]  col_reg;
  logic [SUM_W-1:0]  sum_reg;
  logic              last_acc_reg;  // final pixel of the frame already taken
  logic              line_done_reg;

  logic              hold_full;
  logic [7:0]        hold_byte;
  logic              accept;
  logic              write_done;
  logic              start_ok;

  assign start_ok   = (state_reg == ST_IDLE) & start;
  assign write_done = hold_full & mem_grant;
  assign in_ready   = (state_reg == ST_CAPTURE) & (~hold_full | mem_grant) & ~last_acc_reg;
  assign accept     = in_valid & in_ready;

  pixel_hold_reg u_hold (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .din   (in_byte),
    .drain (write_done),
    .dout  (hold_byte),
    .full  (hold_full)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state: the frame ends on the completed write of the last address.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (start) state_next = ST_CAPTURE;
      ST_CAPTURE: if (write_done && addr_reg == LAST_ADDR) state_next = ST_DONE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // Address, column, accept counter and sum; cleared on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg      <= '0;
      acc_cnt_reg   <= '0;
      col_reg       <= '0;
      sum_reg       <= '0;
      last_acc_reg  <= 1'b0;
      line_done_reg <= 1'b0;
    end else if (start_ok) begin
      addr_reg      <= '0;
      acc_cnt_reg   <= '0;
      col_reg       <= '0;
      sum_reg       <= '0;
      last_acc_reg  <= 1'b0;
      line_done_reg <= 1'b0;
    end else begin
      line_done_reg <= write_done && (col_reg == LAST_COL);
      if (accept) begin
        acc_cnt_reg <= acc_cnt_reg + 1'b1;
        if (acc_cnt_reg == LAST_ADDR) last_acc_reg <= 1'b1;
      end
      if (write_done) begin
        sum_reg <= sum_reg + SUM_W'(hold_byte);
        // The final address is held so it stays visible after the frame.
        if (addr_reg != LAST_ADDR) addr_reg <= addr_reg + 1'b1;
        col_reg <= (col_reg == LAST_COL) ? '0 : col_reg + 1'b1;
      end
    end
  end

  assign mem_we     = hold_full;
  assign mem_wdata  = hold_byte;
  assign mem_addr   = addr_reg;
  assign busy       = (state_reg != ST_IDLE);
  assign frame_done = (state_reg == ST_DONE);
  assign line_done  = line_done_reg;
  assign frame_sum  = sum_reg;

endmodule

// File: tb/tb_pixel_frame_writer.sv
// Bench for pixel_frame_writer: a 4x2 instance exercised with a table of
// frame scenarios and hand-written reset/idle sequences, plus a 256x256
// instance filled with 255 to check the largest sum and final address.
module tb_pixel_frame_writer;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int AW = 16;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, mem_grant;
  logic [7:0]  in_byte;
  logic        in_ready, mem_we, busy, line_done, frame_done;
  logic [AW-1:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [23:0] frame_sum;

  logic        b_start, b_in_valid, b_mem_grant;
  logic [7:0]  b_in_byte;
  logic        b_in_ready, b_mem_we, b_busy, b_line_done, b_frame_done;
  logic [15:0] b_mem_addr;
  logic [7:0]  b_mem_wdata;
  logic [23:0] b_frame_sum;

  always #5 clk = ~clk;

  pixel_frame_writer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_grant(mem_grant), .busy(busy), .line_done(line_done), .frame_done(frame_done),
    .frame_sum(frame_sum)
  );

  pixel_frame_writer #(.IMG_W(256), .IMG_H(256), .ADDR_W(16)) dut_big (
    .clk(clk), .rst(rst), .start(b_start), .in_valid(b_in_valid), .in_byte(b_in_byte),
    .in_ready(b_in_ready), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_grant(b_mem_grant), .busy(b_busy), .line_done(b_line_done), .frame_done(b_frame_done),
    .frame_sum(b_frame_sum)
  );

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    int base;
    bit bubble;
    int stall_addr;
    int stall_len;
    int restart_cyc;
    int exp_sum;
  } vec_t;

  wr_t  exp_q[$];
  int   n_cmp = 0, n_bad = 0;
  int   acc_cnt, wr_cnt, line_cnt, frm_cnt;
  bit   mon_en = 1'b0;
  bit   prev_stall, exp_line, exp_frame;
  logic [15:0] prev_addr;
  logic [7:0]  prev_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pushes on accepted input, pops on completed write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("line_done", 32'(line_done), 32'(exp_line));
        chk("frame_done", 32'(frame_done), 32'(exp_frame));
        if (line_done) line_cnt++;
        if (frame_done) frm_cnt++;
        exp_line = 1'b0;
        exp_frame = 1'b0;
        if (prev_stall) begin
          chk("stall_addr_stable", 32'(mem_addr), 32'(prev_addr));
          chk("stall_data_stable", 32'(mem_wdata), 32'(prev_data));
        end
        prev_stall = mem_we && !mem_grant;
        prev_addr  = mem_addr;
        prev_data  = mem_wdata;
        if (mem_we && !mem_grant) chk("stall_in_ready", 32'(in_ready), 32'd0);
        if (mem_we && mem_grant) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(mem_addr), 32'(e.addr));
            chk("wr_data", 32'(mem_wdata), 32'(e.data));
            wr_cnt++;
            exp_line  = (int'(e.addr) % W) == W - 1;
            exp_frame = int'(e.addr) == W * H - 1;
          end
        end
        if (in_valid && in_ready) begin
          exp_q.push_back('{addr: 16'(acc_cnt), data: in_byte});
          acc_cnt++;
        end
      end
    end
  end

  task automatic mon_reset();
    exp_q.delete();
    acc_cnt = 0; wr_cnt = 0; line_cnt = 0; frm_cnt = 0;
    prev_stall = 1'b0; exp_line = 1'b0; exp_frame = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1; in_valid = 1'b0; mem_grant = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Drives one frame; stops after frame_done or when cycles run out.
  task automatic run_frame(input vec_t v, input int stop_after_wr);
    int cyc = 0, stalls = 0;
    mon_reset();
    pulse_start();
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("addr_after_start", 32'(mem_addr), 32'd0);
    chk("sum_after_start", 32'(frame_sum), 32'd0);
    while (frm_cnt == 0 && wr_cnt < stop_after_wr && cyc < 200) begin
      in_valid  = (acc_cnt < W * H) && (!v.bubble || (cyc % 2 == 0));
      in_byte   = 8'(v.base + acc_cnt);
      start     = (cyc == v.restart_cyc);
      mem_grant = 1'b1;
      if (mem_we && mem_addr == 16'(v.stall_addr) && stalls < v.stall_len) begin
        mem_grant = 1'b0;
        stalls++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; start = 1'b0; mem_grant = 1'b1;
    chk("frame_timeout", 32'(cyc < 200), 32'd1);
    if (v.stall_addr >= 0) chk("stall_cycles", 32'(stalls), 32'(v.stall_len));
  endtask

  vec_t vecs[5];
  int   bw, bf, bcyc;

  initial begin
    vecs[0] = '{base: 1,   bubble: 0, stall_addr: -1, stall_len: 0, restart_cyc: -1, exp_sum: 36};
    vecs[1] = '{base: 1,   bubble: 0, stall_addr: 2,  stall_len: 3, restart_cyc: -1, exp_sum: 36};
    vecs[2] = '{base: 1,   bubble: 1, stall_addr: -1, stall_len: 0, restart_cyc: -1, exp_sum: 36};
    vecs[3] = '{base: 1,   bubble: 0, stall_addr: -1, stall_len: 0, restart_cyc: 3,  exp_sum: 36};
    vecs[4] = '{base: 200, bubble: 0, stall_addr: 5,  stall_len: 2, restart_cyc: -1, exp_sum: 1628};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'd0; mem_grant = 1'b1;
    b_start = 1'b0; b_in_valid = 1'b0; b_in_byte = 8'd255; b_mem_grant = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_line_done", 32'(line_done), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_sum", 32'(frame_sum), 32'd0);
    rst = 1'b0;

    // in_valid in IDLE must be refused and produce no writes.
    mon_reset();
    in_valid = 1'b1; in_byte = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("idle_in_ready", 32'(in_ready), 32'd0);
      chk("idle_mem_we", 32'(mem_we), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end
    in_valid = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i], 1000);
      chk("end_busy", 32'(busy), 32'd0);
      chk("end_frames", 32'(frm_cnt), 32'd1);
      chk("end_writes", 32'(wr_cnt), 32'(W * H));
      chk("end_lines", 32'(line_cnt), 32'(H));
      chk("end_sum", 32'(frame_sum), 32'(vecs[i].exp_sum));
      chk("end_addr", 32'(mem_addr), 32'(W * H - 1));
      chk("end_queue", 32'(exp_q.size()), 32'd0);
      $display("frame %0d: base=%0d bubble=%0d stall@%0d x%0d restart@%0d sum=%0d",
               i, vecs[i].base, vecs[i].bubble, vecs[i].stall_addr, vecs[i].stall_len,
               vecs[i].restart_cyc, frame_sum);
      // Sum and final address stay put while idle.
      repeat (3) @(posedge clk);
      #1;
      chk("held_sum", 32'(frame_sum), 32'(vecs[i].exp_sum));
      chk("held_addr", 32'(mem_addr), 32'(W * H - 1));
    end

    // Reset after addr 4 is written: abandon the frame.
    run_frame(vecs[0], 5);
    chk("midrst_writes", 32'(wr_cnt), 32'd5);
    mon_en = 1'b0;
    rst = 1'b1; in_valid = 1'b1; start = 1'b1; mem_grant = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; start = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_mem_we", 32'(mem_we), 32'd0);
    chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
    chk("midrst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_line_done", 32'(line_done), 32'd0);
    chk("midrst_frame_done", 32'(frame_done), 32'd0);
    chk("midrst_frame_sum", 32'(frame_sum), 32'd0);
    mon_reset();
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_frame_done", 32'(frm_cnt), 32'd0);
    run_frame('{base: 9, bubble: 0, stall_addr: -1, stall_len: 0, restart_cyc: -1, exp_sum: 100}, 1000);
    chk("after_rst_frames", 32'(frm_cnt), 32'd1);
    chk("after_rst_writes", 32'(wr_cnt), 32'(W * H));
    chk("after_rst_sum", 32'(frame_sum), 32'd100);
    chk("after_rst_addr", 32'(mem_addr), 32'(W * H - 1));
    $display("reset mid-frame then restart: sum=%0d addr=%0d", frame_sum, mem_addr);
    mon_en = 1'b0;

    // Full-size frame of 255s on the 256x256 instance.
    bw = 0; bf = 0; bcyc = 0;
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0; b_in_valid = 1'b1;
    while (bf == 0 && bcyc < 70000) begin
      @(negedge clk);
      if (b_mem_we && b_mem_grant) bw++;
      if (b_frame_done) bf++;
      bcyc++;
    end
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    chk("big_timeout", 32'(bcyc < 70000), 32'd1);
    chk("big_frames", 32'(bf), 32'd1);
    chk("big_writes", 32'(bw), 32'd65536);
    chk("big_sum", 32'(b_frame_sum), 32'd16711680);
    chk("big_addr", 32'(b_mem_addr), 32'd65535);
    chk("big_busy", 32'(b_busy), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("big_frame_done_once", 32'(b_frame_done), 32'd0);
    $display("max frame: writes=%0d sum=%0d addr=%0d", bw, b_frame_sum, b_mem_addr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pixel_frame_writer.md
PIXEL_FRAME_WRITER -- requirements
Module: pixel_frame_writer

Interface
REQ-001 Parameter IMG_W, default 256: pixels per row, range 2..256.
REQ-002 Parameter IMG_H, default 256: rows per frame, range 1..256.
REQ-003 Parameter ADDR_W, default 16: frame-buffer address width; IMG_W*IMG_H <= 2^ADDR_W.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high. Ports clk and rst.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  begin capturing one frame; honoured only in IDLE.
REQ-008 in_valid  in  1  in_byte carries a processed pixel.
REQ-009 in_byte  in  8  processed pixel from the pixel-processing stage, MSB first.
REQ-010 in_ready  out  1  writer accepts in_byte this cycle.
REQ-011 mem_we  out  1  write request to the frame buffer.
REQ-012 mem_addr  out  ADDR_W  write address, row-major from 0.
REQ-013 mem_wdata  out  8  write data.
REQ-014 mem_grant  in  1  frame buffer accepts the write this cycle.
REQ-015 busy  out  1  state is not IDLE.
REQ-016 line_done  out  1  one-cycle pulse after the last pixel of a row is written.
REQ-017 frame_done  out  1  one-cycle pulse after the last pixel of the frame is written.
REQ-018 frame_sum  out  24  sum of all pixels written in the current or last frame.

Function
REQ-019 States: IDLE, CAPTURE, DONE.
REQ-020 IDLE->CAPTURE when start=1. On that edge the writer clears the address, column counter and frame_sum.
REQ-021 A one-entry hold register sits between input and memory. Input transfer: in_valid & in_ready.
REQ-022 in_ready = (state==CAPTURE) & (hold empty | mem_grant) & (the last frame pixel has not yet been accepted).
REQ-023 An accepted byte is loaded into hold at the next edge. mem_we = hold full. mem_wdata = hold byte. Latency from accept to mem_we is 1 cycle.
REQ-024 A write completes when mem_we & mem_grant. In that cycle a new byte may load hold, giving full throughput of 1 pixel/clk.
REQ-025 While mem_we=1 and mem_grant=0, mem_addr and mem_wdata hold stable, and no byte is accepted.
REQ-026 On each completed write, mem_addr increments by 1 and frame_sum += mem_wdata. frame_sum is 24-bit and cannot overflow for the maximum frame size.
REQ-027 The column counter wraps at IMG_W-1. A completed write at column IMG_W-1 sets line_done=1 for the following cycle.
REQ-028 A completed write at address IMG_W*IMG_H-1 moves CAPTURE->DONE. In DONE, frame_done=1 and line_done=1 for one cycle, then the block returns to IDLE.
REQ-029 start outside IDLE is ignored. in_valid outside CAPTURE is ignored, with in_ready=0.
REQ-030 frame_sum and the final mem_addr are held from DONE until the next accepted start.

Reset
REQ-031 rst=1 at an edge forces IDLE and empties hold. in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, line_done=0, frame_done=0, frame_sum=0.
REQ-032 rst mid-frame abandons the frame. No frame_done is produced, and the next start begins at address 0.
REQ-033 rst has priority over start, in_valid and mem_grant in the same cycle.

Structure
REQ-034 A shared package holds the state encoding (IDLE/CAPTURE/DONE), the default IMG_W/IMG_H/ADDR_W constants and the 24-bit sum width constant.
REQ-035 The one-entry hold register is the sub-module pixel_hold_reg, with ports clk, rst, load, din[8], drain, dout[8] and full. FSM, counters and sum live in the top.

Verification (IMG_W=4, IMG_H=2 unless noted)
REQ-036 Stream: start, then in_valid=1 with bytes 1..8 and mem_grant=1 -> writes at addr 0..7 with data 1..8 on consecutive cycles; line_done after addr 3 and addr 7; frame_done once; frame_sum=36.
REQ-037 Backpressure: mem_grant=0 for 3 cycles while the byte for addr 2 is pending -> mem_addr=2 and data stable for 3 cycles, in_ready=0, no byte lost, final frame_sum=36.
REQ-038 Bubbles: in_valid toggles 1,0,1,0,... -> mem_we only for valid bytes, addresses contiguous 0..7, frame_done after 8 writes.
REQ-039 Reset mid-frame: rst after addr 4 is written -> all outputs zero next cycle, no frame_done; a new start with bytes 9..16 -> addr 0..7, frame_sum=100.
REQ-040 Ignored controls: start pulsed during CAPTURE, and in_valid=1 in IDLE -> no restart, no writes in IDLE, in_ready=0 in IDLE.
REQ-041 Max value: IMG_W=256, IMG_H=256, all bytes 255 -> frame_sum=16711680, final mem_addr=65535, frame_done once.
